// File: rtl/axi_svt_reg_slice.sv
// AXI register slice: one two-entry skid buffer per channel (AW, W, AR forward; R, B backward),
// each individually selectable between registered and wire-through.

`ifndef SVT_AXI_MAX_ADDR_WIDTH
`define SVT_AXI_MAX_ADDR_WIDTH 32
`endif
`ifndef SVT_AXI_MAX_DATA_WIDTH
`define SVT_AXI_MAX_DATA_WIDTH 32
`endif
`ifndef SVT_AXI_MAX_ID_WIDTH
`define SVT_AXI_MAX_ID_WIDTH 4
`endif
`ifndef SVT_AXI_MAX_BURST_LENGTH_WIDTH
`define SVT_AXI_MAX_BURST_LENGTH_WIDTH 8
`endif
`ifndef SVT_AXI_SIZE_WIDTH
`define SVT_AXI_SIZE_WIDTH 3
`endif
`ifndef SVT_AXI_BURST_WIDTH
`define SVT_AXI_BURST_WIDTH 2
`endif
`ifndef SVT_AXI_LOCK_WIDTH
`define SVT_AXI_LOCK_WIDTH 2
`endif
`ifndef SVT_AXI_PROT_WIDTH
`define SVT_AXI_PROT_WIDTH 3
`endif
`ifndef SVT_AXI_CACHE_WIDTH
`define SVT_AXI_CACHE_WIDTH 4
`endif
`ifndef SVT_AXI_RESP_WIDTH
`define SVT_AXI_RESP_WIDTH 2
`endif

module axi_svt_reg_slice_chan #(
    parameter int WIDTH = 8,
    parameter bit SLICE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic             dst_valid,
    input  logic             dst_ready,
    output logic [WIDTH-1:0] dst_data
);

    generate
        if (SLICE) begin : g_reg
            // bit0 = main entry valid, bit1 = skid entry valid; both drive outputs directly
            localparam logic [1:0] EMPTY = 2'b00;
            localparam logic [1:0] ONE   = 2'b01;
            localparam logic [1:0] TWO   = 2'b11;

            logic [1:0]       state_reg;
            logic [WIDTH-1:0] main_reg;
            logic [WIDTH-1:0] skid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= EMPTY;
                    main_reg  <= '0;
                    skid_reg  <= '0;
                end else begin
                    case (state_reg)
                        EMPTY: begin
                            if (src_valid) begin
                                main_reg  <= src_data;
                                state_reg <= ONE;
                            end
                        end
                        ONE: begin
                            if (src_valid && dst_ready) begin
                                main_reg <= src_data;
                            end else if (src_valid) begin
                                skid_reg  <= src_data;
                                state_reg <= TWO;
                            end else if (dst_ready) begin
                                state_reg <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (dst_ready) begin
                                main_reg  <= skid_reg;
                                state_reg <= ONE;
                            end
                        end
                        default: state_reg <= EMPTY;
                    endcase
                end
            end

            assign dst_valid = state_reg[0];
            assign src_ready = ~state_reg[1];
            assign dst_data  = main_reg;
        end else begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign dst_valid      = src_valid;
            assign src_ready      = dst_ready;
            assign dst_data       = src_data;
        end
    endgenerate

endmodule

module axi_svt_reg_slice #(
    parameter bit AW_SLICE = 1'b1,
    parameter bit W_SLICE  = 1'b1,
    parameter bit AR_SLICE = 1'b1,
    parameter bit R_SLICE  = 1'b1,
    parameter bit B_SLICE  = 1'b1
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    // AW
    input  logic                                       awvalid_up,
    output logic                                       awready_up,
    input  logic [`SVT_AXI_MAX_ADDR_WIDTH-1:0]         awaddr_up,
    input  logic [`SVT_AXI_MAX_BURST_LENGTH_WIDTH-1:0] awlen_up,
    input  logic [`SVT_AXI_SIZE_WIDTH-1:0]             awsize_up,
    input  logic [`SVT_AXI_BURST_WIDTH-1:0]            awburst_up,
    input  logic [`SVT_AXI_LOCK_WIDTH-1:0]             awlock_up,
    input  logic [`SVT_AXI_PROT_WIDTH-1:0]             awprot_up,
    input  logic [`SVT_AXI_CACHE_WIDTH-1:0]            awcache_up,
    input  logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           awid_up,
    output logic                                       awvalid_dn,
    input  logic                                       awready_dn,
    output logic [`SVT_AXI_MAX_ADDR_WIDTH-1:0]         awaddr_dn,
    output logic [`SVT_AXI_MAX_BURST_LENGTH_WIDTH-1:0] awlen_dn,
    output logic [`SVT_AXI_SIZE_WIDTH-1:0]             awsize_dn,
    output logic [`SVT_AXI_BURST_WIDTH-1:0]            awburst_dn,
    output logic [`SVT_AXI_LOCK_WIDTH-1:0]             awlock_dn,
    output logic [`SVT_AXI_PROT_WIDTH-1:0]             awprot_dn,
    output logic [`SVT_AXI_CACHE_WIDTH-1:0]            awcache_dn,
    output logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           awid_dn,
    // AR
    input  logic                                       arvalid_up,
    output logic                                       arready_up,
    input  logic [`SVT_AXI_MAX_ADDR_WIDTH-1:0]         araddr_up,
    input  logic [`SVT_AXI_MAX_BURST_LENGTH_WIDTH-1:0] arlen_up,
    input  logic [`SVT_AXI_SIZE_WIDTH-1:0]             arsize_up,
    input  logic [`SVT_AXI_BURST_WIDTH-1:0]            arburst_up,
    input  logic [`SVT_AXI_LOCK_WIDTH-1:0]             arlock_up,
    input  logic [`SVT_AXI_PROT_WIDTH-1:0]             arprot_up,
    input  logic [`SVT_AXI_CACHE_WIDTH-1:0]            arcache_up,
    input  logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           arid_up,
    output logic                                       arvalid_dn,
    input  logic                                       arready_dn,
    output logic [`SVT_AXI_MAX_ADDR_WIDTH-1:0]         araddr_dn,
    output logic [`SVT_AXI_MAX_BURST_LENGTH_WIDTH-1:0] arlen_dn,
    output logic [`SVT_AXI_SIZE_WIDTH-1:0]             arsize_dn,
    output logic [`SVT_AXI_BURST_WIDTH-1:0]            arburst_dn,
    output logic [`SVT_AXI_LOCK_WIDTH-1:0]             arlock_dn,
    output logic [`SVT_AXI_PROT_WIDTH-1:0]             arprot_dn,
    output logic [`SVT_AXI_CACHE_WIDTH-1:0]            arcache_dn,
    output logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           arid_dn,
    // W
    input  logic                                       wvalid_up,
    output logic                                       wready_up,
    input  logic [`SVT_AXI_MAX_DATA_WIDTH-1:0]         wdata_up,
    input  logic [`SVT_AXI_MAX_DATA_WIDTH/8-1:0]       wstrb_up,
    input  logic                                       wlast_up,
    input  logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           wid_up,
    output logic                                       wvalid_dn,
    input  logic                                       wready_dn,
    output logic [`SVT_AXI_MAX_DATA_WIDTH-1:0]         wdata_dn,
    output logic [`SVT_AXI_MAX_DATA_WIDTH/8-1:0]       wstrb_dn,
    output logic                                       wlast_dn,
    output logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           wid_dn,
    // R
    input  logic                                       rvalid_dn,
    output logic                                       rready_dn,
    input  logic [`SVT_AXI_MAX_DATA_WIDTH-1:0]         rdata_dn,
    input  logic                                       rlast_dn,
    input  logic [`SVT_AXI_RESP_WIDTH-1:0]             rresp_dn,
    input  logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           rid_dn,
    output logic                                       rvalid_up,
    input  logic                                       rready_up,
    output logic [`SVT_AXI_MAX_DATA_WIDTH-1:0]         rdata_up,
    output logic                                       rlast_up,
    output logic [`SVT_AXI_RESP_WIDTH-1:0]             rresp_up,
    output logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           rid_up,
    // B
    input  logic                                       bvalid_dn,
    output logic                                       bready_dn,
    input  logic [`SVT_AXI_RESP_WIDTH-1:0]             bresp_dn,
    input  logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           bid_dn,
    output logic                                       bvalid_up,
    input  logic                                       bready_up,
    output logic [`SVT_AXI_RESP_WIDTH-1:0]             bresp_up,
    output logic [`SVT_AXI_MAX_ID_WIDTH-1:0]           bid_up
);

    localparam int AX_W = `SVT_AXI_MAX_ADDR_WIDTH + `SVT_AXI_MAX_BURST_LENGTH_WIDTH
                        + `SVT_AXI_SIZE_WIDTH + `SVT_AXI_BURST_WIDTH + `SVT_AXI_LOCK_WIDTH
                        + `SVT_AXI_PROT_WIDTH + `SVT_AXI_CACHE_WIDTH + `SVT_AXI_MAX_ID_WIDTH;
    localparam int W_W  = `SVT_AXI_MAX_DATA_WIDTH + `SVT_AXI_MAX_DATA_WIDTH/8 + 1
                        + `SVT_AXI_MAX_ID_WIDTH;
    localparam int R_W  = `SVT_AXI_MAX_DATA_WIDTH + 1 + `SVT_AXI_RESP_WIDTH
                        + `SVT_AXI_MAX_ID_WIDTH;
    localparam int B_W  = `SVT_AXI_RESP_WIDTH + `SVT_AXI_MAX_ID_WIDTH;

    logic [AX_W-1:0] aw_src, aw_dst, ar_src, ar_dst;
    logic [W_W-1:0]  w_src, w_dst;
    logic [R_W-1:0]  r_src, r_dst;
    logic [B_W-1:0]  b_src, b_dst;

    // Payloads travel as opaque vectors; field order only matters for pack/unpack symmetry
    assign aw_src = {awaddr_up, awlen_up, awsize_up, awburst_up, awlock_up, awprot_up, awcache_up, awid_up};
    assign {awaddr_dn, awlen_dn, awsize_dn, awburst_dn, awlock_dn, awprot_dn, awcache_dn, awid_dn} = aw_dst;
    assign ar_src = {araddr_up, arlen_up, arsize_up, arburst_up, arlock_up, arprot_up, arcache_up, arid_up};
    assign {araddr_dn, arlen_dn, arsize_dn, arburst_dn, arlock_dn, arprot_dn, arcache_dn, arid_dn} = ar_dst;
    assign w_src  = {wdata_up, wstrb_up, wlast_up, wid_up};
    assign {wdata_dn, wstrb_dn, wlast_dn, wid_dn} = w_dst;
    assign r_src  = {rdata_dn, rlast_dn, rresp_dn, rid_dn};
    assign {rdata_up, rlast_up, rresp_up, rid_up} = r_dst;
    assign b_src  = {bresp_dn, bid_dn};
    assign {bresp_up, bid_up} = b_dst;

    axi_svt_reg_slice_chan #(.WIDTH(AX_W), .SLICE(AW_SLICE)) u_aw (
        .clk(aclk), .rst_n(aresetn),
        .src_valid(awvalid_up), .src_ready(awready_up), .src_data(aw_src),
        .dst_valid(awvalid_dn), .dst_ready(awready_dn), .dst_data(aw_dst)
    );

    axi_svt_reg_slice_chan #(.WIDTH(W_W), .SLICE(W_SLICE)) u_w (
        .clk(aclk), .rst_n(aresetn),
        .src_valid(wvalid_up), .src_ready(wready_up), .src_data(w_src),
        .dst_valid(wvalid_dn), .dst_ready(wready_dn), .dst_data(w_dst)
    );

    axi_svt_reg_slice_chan #(.WIDTH(AX_W), .SLICE(AR_SLICE)) u_ar (
        .clk(aclk), .rst_n(aresetn),
        .src_valid(arvalid_up), .src_ready(arready_up), .src_data(ar_src),
        .dst_valid(arvalid_dn), .dst_ready(arready_dn), .dst_data(ar_dst)
    );

    axi_svt_reg_slice_chan #(.WIDTH(R_W), .SLICE(R_SLICE)) u_r (
        .clk(aclk), .rst_n(aresetn),
        .src_valid(rvalid_dn), .src_ready(rready_dn), .src_data(r_src),
        .dst_valid(rvalid_up), .dst_ready(rready_up), .dst_data(r_dst)
    );

    axi_svt_reg_slice_chan #(.WIDTH(B_W), .SLICE(B_SLICE)) u_b (
        .clk(aclk), .rst_n(aresetn),
        .src_valid(bvalid_dn), .src_ready(bready_dn), .src_data(b_src),
        .dst_valid(bvalid_up), .dst_ready(bready_up), .dst_data(b_dst)
    );

endmodule

// File: tb/tb_axi_svt_reg_slice.sv
// Bench for axi_svt_reg_slice: a two-deep FIFO model per channel checked every cycle,
// plus directed scenarios with literal expectations. A second instance uses AW_SLICE=0.

module tb_axi_svt_reg_slice;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    // AW
    logic awvalid_up, awready_up, awvalid_dn, awready_dn;
    logic [31:0] awaddr_up, awaddr_dn;
    logic [7:0]  awlen_up, awlen_dn;
    logic [2:0]  awsize_up, awsize_dn, awprot_up, awprot_dn;
    logic [1:0]  awburst_up, awburst_dn, awlock_up, awlock_dn;
    logic [3:0]  awcache_up, awcache_dn, awid_up, awid_dn;
    // AR
    logic arvalid_up, arready_up, arvalid_dn, arready_dn;
    logic [31:0] araddr_up, araddr_dn;
    logic [7:0]  arlen_up, arlen_dn;
    logic [2:0]  arsize_up, arsize_dn, arprot_up, arprot_dn;
    logic [1:0]  arburst_up, arburst_dn, arlock_up, arlock_dn;
    logic [3:0]  arcache_up, arcache_dn, arid_up, arid_dn;
    // W
    logic wvalid_up, wready_up, wvalid_dn, wready_dn, wlast_up, wlast_dn;
    logic [31:0] wdata_up, wdata_dn;
    logic [3:0]  wstrb_up, wstrb_dn, wid_up, wid_dn;
    // R
    logic rvalid_dn, rready_dn, rvalid_up, rready_up, rlast_dn, rlast_up;
    logic [31:0] rdata_dn, rdata_up;
    logic [1:0]  rresp_dn, rresp_up;
    logic [3:0]  rid_dn, rid_up;
    // B
    logic bvalid_dn, bready_dn, bvalid_up, bready_up;
    logic [1:0]  bresp_dn, bresp_up;
    logic [3:0]  bid_dn, bid_up;

    // outputs of the AW_SLICE=0 instance
    logic p_awready_up, p_awvalid_dn, p_arready_up, p_arvalid_dn;
    logic [31:0] p_awaddr_dn, p_araddr_dn;
    logic [7:0]  p_awlen_dn, p_arlen_dn;
    logic [2:0]  p_awsize_dn, p_awprot_dn, p_arsize_dn, p_arprot_dn;
    logic [1:0]  p_awburst_dn, p_awlock_dn, p_arburst_dn, p_arlock_dn;
    logic [3:0]  p_awcache_dn, p_awid_dn, p_arcache_dn, p_arid_dn;
    logic p_wready_up, p_wvalid_dn, p_wlast_dn;
    logic [31:0] p_wdata_dn;
    logic [3:0]  p_wstrb_dn, p_wid_dn;
    logic p_rready_dn, p_rvalid_up, p_rlast_up;
    logic [31:0] p_rdata_up;
    logic [1:0]  p_rresp_up;
    logic [3:0]  p_rid_up;
    logic p_bready_dn, p_bvalid_up;
    logic [1:0]  p_bresp_up;
    logic [3:0]  p_bid_up;

    axi_svt_reg_slice dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid_up(awvalid_up), .awready_up(awready_up), .awaddr_up(awaddr_up), .awlen_up(awlen_up),
        .awsize_up(awsize_up), .awburst_up(awburst_up), .awlock_up(awlock_up), .awprot_up(awprot_up),
        .awcache_up(awcache_up), .awid_up(awid_up),
        .awvalid_dn(awvalid_dn), .awready_dn(awready_dn), .awaddr_dn(awaddr_dn), .awlen_dn(awlen_dn),
        .awsize_dn(awsize_dn), .awburst_dn(awburst_dn), .awlock_dn(awlock_dn), .awprot_dn(awprot_dn),
        .awcache_dn(awcache_dn), .awid_dn(awid_dn),
        .arvalid_up(arvalid_up), .arready_up(arready_up), .araddr_up(araddr_up), .arlen_up(arlen_up),
        .arsize_up(arsize_up), .arburst_up(arburst_up), .arlock_up(arlock_up), .arprot_up(arprot_up),
        .arcache_up(arcache_up), .arid_up(arid_up),
        .arvalid_dn(arvalid_dn), .arready_dn(arready_dn), .araddr_dn(araddr_dn), .arlen_dn(arlen_dn),
        .arsize_dn(arsize_dn), .arburst_dn(arburst_dn), .arlock_dn(arlock_dn), .arprot_dn(arprot_dn),
        .arcache_dn(arcache_dn), .arid_dn(arid_dn),
        .wvalid_up(wvalid_up), .wready_up(wready_up), .wdata_up(wdata_up), .wstrb_up(wstrb_up),
        .wlast_up(wlast_up), .wid_up(wid_up),
        .wvalid_dn(wvalid_dn), .wready_dn(wready_dn), .wdata_dn(wdata_dn), .wstrb_dn(wstrb_dn),
        .wlast_dn(wlast_dn), .wid_dn(wid_dn),
        .rvalid_dn(rvalid_dn), .rready_dn(rready_dn), .rdata_dn(rdata_dn), .rlast_dn(rlast_dn),
        .rresp_dn(rresp_dn), .rid_dn(rid_dn),
        .rvalid_up(rvalid_up), .rready_up(rready_up), .rdata_up(rdata_up), .rlast_up(rlast_up),
        .rresp_up(rresp_up), .rid_up(rid_up),
        .bvalid_dn(bvalid_dn), .bready_dn(bready_dn), .bresp_dn(bresp_dn), .bid_dn(bid_dn),
        .bvalid_up(bvalid_up), .bready_up(bready_up), .bresp_up(bresp_up), .bid_up(bid_up)
    );

    axi_svt_reg_slice #(.AW_SLICE(1'b0)) dut_pass (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid_up(awvalid_up), .awready_up(p_awready_up), .awaddr_up(awaddr_up), .awlen_up(awlen_up),
        .awsize_up(awsize_up), .awburst_up(awburst_up), .awlock_up(awlock_up), .awprot_up(awprot_up),
        .awcache_up(awcache_up), .awid_up(awid_up),
        .awvalid_dn(p_awvalid_dn), .awready_dn(awready_dn), .awaddr_dn(p_awaddr_dn), .awlen_dn(p_awlen_dn),
        .awsize_dn(p_awsize_dn), .awburst_dn(p_awburst_dn), .awlock_dn(p_awlock_dn), .awprot_dn(p_awprot_dn),
        .awcache_dn(p_awcache_dn), .awid_dn(p_awid_dn),
        .arvalid_up(arvalid_up), .arready_up(p_arready_up), .araddr_up(araddr_up), .arlen_up(arlen_up),
        .arsize_up(arsize_up), .arburst_up(arburst_up), .arlock_up(arlock_up), .arprot_up(arprot_up),
        .arcache_up(arcache_up), .arid_up(arid_up),
        .arvalid_dn(p_arvalid_dn), .arready_dn(arready_dn), .araddr_dn(p_araddr_dn), .arlen_dn(p_arlen_dn),
        .arsize_dn(p_arsize_dn), .arburst_dn(p_arburst_dn), .arlock_dn(p_arlock_dn), .arprot_dn(p_arprot_dn),
        .arcache_dn(p_arcache_dn), .arid_dn(p_arid_dn),
        .wvalid_up(wvalid_up), .wready_up(p_wready_up), .wdata_up(wdata_up), .wstrb_up(wstrb_up),
        .wlast_up(wlast_up), .wid_up(wid_up),
        .wvalid_dn(p_wvalid_dn), .wready_dn(wready_dn), .wdata_dn(p_wdata_dn), .wstrb_dn(p_wstrb_dn),
        .wlast_dn(p_wlast_dn), .wid_dn(p_wid_dn),
        .rvalid_dn(rvalid_dn), .rready_dn(p_rready_dn), .rdata_dn(rdata_dn), .rlast_dn(rlast_dn),
        .rresp_dn(rresp_dn), .rid_dn(rid_dn),
        .rvalid_up(p_rvalid_up), .rready_up(rready_up), .rdata_up(p_rdata_up), .rlast_up(p_rlast_up),
        .rresp_up(p_rresp_up), .rid_up(p_rid_up),
        .bvalid_dn(bvalid_dn), .bready_dn(p_bready_dn), .bresp_dn(bresp_dn), .bid_dn(bid_dn),
        .bvalid_up(p_bvalid_up), .bready_up(bready_up), .bresp_up(p_bresp_up), .bid_up(p_bid_up)
    );

    // channel index: 0 aw, 1 w, 2 ar, 3 r, 4 b
    logic [4:0]  src_valid_v, src_ready_v, dst_valid_v, dst_ready_v, p_src_ready_v, p_dst_valid_v;
    logic [63:0] src_pay [5];
    logic [63:0] dst_pay [5];
    logic [63:0] p_dst_pay [5];
    string       chn [5] = '{"aw", "w", "ar", "r", "b"};

    assign src_valid_v   = {bvalid_dn, rvalid_dn, arvalid_up, wvalid_up, awvalid_up};
    assign dst_ready_v   = {bready_up, rready_up, arready_dn, wready_dn, awready_dn};
    assign dst_valid_v   = {bvalid_up, rvalid_up, arvalid_dn, wvalid_dn, awvalid_dn};
    assign src_ready_v   = {bready_dn, rready_dn, arready_up, wready_up, awready_up};
    assign p_dst_valid_v = {p_bvalid_up, p_rvalid_up, p_arvalid_dn, p_wvalid_dn, p_awvalid_dn};
    assign p_src_ready_v = {p_bready_dn, p_rready_dn, p_arready_up, p_wready_up, p_awready_up};

    assign src_pay[0]   = 64'({awaddr_up, awlen_up, awsize_up, awburst_up, awlock_up, awprot_up, awcache_up, awid_up});
    assign dst_pay[0]   = 64'({awaddr_dn, awlen_dn, awsize_dn, awburst_dn, awlock_dn, awprot_dn, awcache_dn, awid_dn});
    assign p_dst_pay[0] = 64'({p_awaddr_dn, p_awlen_dn, p_awsize_dn, p_awburst_dn, p_awlock_dn, p_awprot_dn, p_awcache_dn, p_awid_dn});
    assign src_pay[1]   = 64'({wdata_up, wstrb_up, wlast_up, wid_up});
    assign dst_pay[1]   = 64'({wdata_dn, wstrb_dn, wlast_dn, wid_dn});
    assign p_dst_pay[1] = 64'({p_wdata_dn, p_wstrb_dn, p_wlast_dn, p_wid_dn});
    assign src_pay[2]   = 64'({araddr_up, arlen_up, arsize_up, arburst_up, arlock_up, arprot_up, arcache_up, arid_up});
    assign dst_pay[2]   = 64'({araddr_dn, arlen_dn, arsize_dn, arburst_dn, arlock_dn, arprot_dn, arcache_dn, arid_dn});
    assign p_dst_pay[2] = 64'({p_araddr_dn, p_arlen_dn, p_arsize_dn, p_arburst_dn, p_arlock_dn, p_arprot_dn, p_arcache_dn, p_arid_dn});
    assign src_pay[3]   = 64'({rdata_dn, rlast_dn, rresp_dn, rid_dn});
    assign dst_pay[3]   = 64'({rdata_up, rlast_up, rresp_up, rid_up});
    assign p_dst_pay[3] = 64'({p_rdata_up, p_rlast_up, p_rresp_up, p_rid_up});
    assign src_pay[4]   = 64'({bresp_dn, bid_dn});
    assign dst_pay[4]   = 64'({bresp_up, bid_up});
    assign p_dst_pay[4] = 64'({p_bresp_up, p_bid_up});

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each registered channel is a two-deep FIFO; a beat pushed at an edge is visible after it.
    logic [63:0] mbuf [5][2];
    int          mcnt [5];
    logic        s_hs, d_hs;

    initial begin
        for (int ch = 0; ch < 5; ch++) mcnt[ch] = 0;
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                for (int ch = 0; ch < 5; ch++) mcnt[ch] = 0;
            end else begin
                for (int ch = 0; ch < 5; ch++) begin
                    s_hs = src_valid_v[ch] && (mcnt[ch] < 2);
                    d_hs = (mcnt[ch] > 0) && dst_ready_v[ch];
                    if (d_hs) begin
                        mbuf[ch][0] = mbuf[ch][1];
                        mcnt[ch]--;
                    end
                    if (s_hs) begin
                        mbuf[ch][mcnt[ch]] = src_pay[ch];
                        mcnt[ch]++;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    initial begin
        forever begin
            @(negedge aclk);
            for (int ch = 0; ch < 5; ch++) begin
                check($sformatf("%s_dst_valid", chn[ch]), 64'(dst_valid_v[ch]), 64'(mcnt[ch] > 0));
                check($sformatf("%s_src_ready", chn[ch]), 64'(src_ready_v[ch]), 64'(mcnt[ch] < 2));
                if (mcnt[ch] > 0) check($sformatf("%s_dst_payload", chn[ch]), dst_pay[ch], mbuf[ch][0]);
                if (ch == 0) begin
                    check("pass_aw_valid", 64'(p_dst_valid_v[0]), 64'(src_valid_v[0]));
                    check("pass_aw_ready", 64'(p_src_ready_v[0]), 64'(dst_ready_v[0]));
                    check("pass_aw_payload", p_dst_pay[0], src_pay[0]);
                end else begin
                    check($sformatf("pass_%s_dst_valid", chn[ch]), 64'(p_dst_valid_v[ch]), 64'(mcnt[ch] > 0));
                    check($sformatf("pass_%s_src_ready", chn[ch]), 64'(p_src_ready_v[ch]), 64'(mcnt[ch] < 2));
                    if (mcnt[ch] > 0) check($sformatf("pass_%s_dst_payload", chn[ch]), p_dst_pay[ch], mbuf[ch][0]);
                end
            end
        end
    end

    // Log of delivered beats on the main instance (cleared by reset)
    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [3:0]  id;
        logic [31:0] cyc;
    } beat_t;
    beat_t aw_q[$], w_q[$], ar_q[$], r_q[$], b_q[$];
    logic [31:0] cyc = 0;

    initial begin
        forever begin
            @(posedge aclk or negedge aresetn);
            if (!aresetn) begin
                aw_q.delete(); w_q.delete(); ar_q.delete(); r_q.delete(); b_q.delete();
            end else begin
                cyc++;
                if (awvalid_dn && awready_dn) aw_q.push_back({awaddr_dn, 1'b0, awid_dn, cyc});
                if (wvalid_dn && wready_dn)   w_q.push_back({wdata_dn, wlast_dn, wid_dn, cyc});
                if (arvalid_dn && arready_dn) ar_q.push_back({araddr_dn, 1'b0, arid_dn, cyc});
                if (rvalid_up && rready_up)   r_q.push_back({rdata_up, rlast_up, rid_up, cyc});
                if (bvalid_up && bready_up)   b_q.push_back({30'd0, bresp_up, 1'b0, bid_up, cyc});
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    int   sent, c, low_cycles, first_low, w_drop;
    logic acc;
    beat_t bt;

    initial begin
        aresetn = 1'b0;
        awvalid_up = 1'b1; awaddr_up = 32'h1000; awlen_up = 8'd0; awsize_up = 3'd2; awburst_up = 2'd1;
        awlock_up = 2'd0; awprot_up = 3'd0; awcache_up = 4'd3; awid_up = 4'd3; awready_dn = 1'b0;
        arvalid_up = 1'b0; araddr_up = 32'h0; arlen_up = 8'd0; arsize_up = 3'd2; arburst_up = 2'd1;
        arlock_up = 2'd0; arprot_up = 3'd0; arcache_up = 4'd0; arid_up = 4'd0; arready_dn = 1'b1;
        wvalid_up = 1'b0; wdata_up = 32'h0; wstrb_up = 4'hf; wlast_up = 1'b0; wid_up = 4'd1; wready_dn = 1'b1;
        rvalid_dn = 1'b0; rdata_dn = 32'h0; rlast_dn = 1'b0; rresp_dn = 2'd0; rid_dn = 4'd0; rready_up = 1'b1;
        bvalid_dn = 1'b0; bresp_dn = 2'd0; bid_dn = 4'd0; bready_up = 1'b1;

        // reset with awvalid_up held high
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_awvalid_dn", 64'(awvalid_dn), 64'd0);
        check("rst_awaddr_dn", 64'(awaddr_dn), 64'd0);
        check("rst_awready_up", 64'(awready_up), 64'd1);
        check("rst_wvalid_dn", 64'(wvalid_dn), 64'd0);
        check("rst_rvalid_up", 64'(rvalid_up), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("aw_before_accept", 64'(awvalid_dn), 64'd0);
        tick();
        awvalid_up = 1'b0;
        @(negedge aclk);
        check("aw_first_valid", 64'(awvalid_dn), 64'd1);
        check("aw_first_addr", 64'(awaddr_dn), 64'h1000);
        check("aw_first_id", 64'(awid_dn), 64'd3);
        awready_dn = 1'b1;
        tick();
        check("aw_drained", 64'(awvalid_dn), 64'd0);
        check("aw_log_count", 64'(aw_q.size()), 64'd1);

        // 8-beat W burst at full rate
        w_drop = 0;
        for (int i = 0; i < 8; i++) begin
            wvalid_up = 1'b1; wdata_up = 32'(i); wlast_up = (i == 7);
            @(posedge aclk);
            if (!wready_up) w_drop++;
            #1;
        end
        wvalid_up = 1'b0; wlast_up = 1'b0;
        repeat (3) tick();
        check("wburst_count", 64'(w_q.size()), 64'd8);
        check("wburst_ready_drops", 64'(w_drop), 64'd0);
        for (int i = 0; i < 8; i++) begin
            bt = (i < w_q.size()) ? w_q[i] : '1;
            check($sformatf("wburst_data%0d", i), 64'(bt.d), 64'(i));
            check($sformatf("wburst_last%0d", i), 64'(bt.l), 64'(i == 7));
            if (i > 0 && w_q.size() == 8) check($sformatf("wburst_consec%0d", i), 64'(w_q[i].cyc - w_q[i-1].cyc), 64'd1);
        end

        // W backpressure: wready_dn low for 4 cycles mid-stream
        w_q.delete();
        sent = 0; c = 0; low_cycles = 0; first_low = -1;
        while (sent < 8 && c < 40) begin
            wvalid_up = 1'b1; wdata_up = 32'h10 + 32'(sent); wlast_up = (sent == 7);
            wready_dn = !(c >= 2 && c < 6);
            @(posedge aclk);
            acc = wready_up;
            #1;
            if (!acc) begin
                low_cycles++;
                if (first_low < 0) first_low = sent;
            end else begin
                sent++;
            end
            if (c >= 2 && c < 6) begin
                check("bp_wvalid_hold", 64'(wvalid_dn), 64'd1);
                check("bp_wdata_hold", 64'(wdata_dn), 64'h11);
            end
            c++;
        end
        wvalid_up = 1'b0; wlast_up = 1'b0; wready_dn = 1'b1;
        repeat (3) tick();
        check("bp_all_sent", 64'(sent), 64'd8);
        check("bp_first_low_after", 64'(first_low), 64'd3);
        check("bp_low_cycles", 64'(low_cycles), 64'd4);
        check("bp_count", 64'(w_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            bt = (i < w_q.size()) ? w_q[i] : '1;
            check($sformatf("bp_data%0d", i), 64'(bt.d), 64'h10 + 64'(i));
        end

        // R: 4 beats with rready_up toggling
        r_q.delete();
        sent = 0; c = 0;
        while ((sent < 4 || r_q.size() < 4) && c < 40) begin
            rready_up = (c % 2 == 0);
            rvalid_dn = (sent < 4); rdata_dn = 32'hA0 + 32'(sent); rlast_dn = (sent == 3);
            rid_dn = 4'd5; rresp_dn = 2'd0;
            @(posedge aclk);
            acc = rready_dn && rvalid_dn;
            #1;
            if (acc) sent++;
            c++;
        end
        rvalid_dn = 1'b0; rlast_dn = 1'b0; rready_up = 1'b1;
        repeat (2) tick();
        check("r_handshakes", 64'(r_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            bt = (i < r_q.size()) ? r_q[i] : '1;
            check($sformatf("r_data%0d", i), 64'(bt.d), 64'hA0 + 64'(i));
            check($sformatf("r_last%0d", i), 64'(bt.l), 64'(i == 3));
            check($sformatf("r_id%0d", i), 64'(bt.id), 64'd5);
        end

        // B: simultaneous src/dst handshake in state ONE
        b_q.delete();
        bvalid_dn = 1'b1; bid_dn = 4'd1;
        @(posedge aclk);
        check("b_ready_edge1", 64'(bready_dn), 64'd1);
        #1;
        bid_dn = 4'd2;
        @(posedge aclk);
        check("b_ready_edge2", 64'(bready_dn), 64'd1);
        #1;
        bvalid_dn = 1'b0;
        repeat (2) tick();
        check("b_count", 64'(b_q.size()), 64'd2);
        if (b_q.size() == 2) begin
            check("b_first_id", 64'(b_q[0].id), 64'd1);
            check("b_second_id", 64'(b_q[1].id), 64'd2);
            check("b_consecutive", 64'(b_q[1].cyc - b_q[0].cyc), 64'd1);
        end

        // AR: fill to two entries, then asynchronous reset mid-cycle
        arready_dn = 1'b0;
        arvalid_up = 1'b1; araddr_up = 32'h100; arid_up = 4'd1;
        tick();
        araddr_up = 32'h104;
        tick();
        arvalid_up = 1'b0;
        check("ar_full_valid", 64'(arvalid_dn), 64'd1);
        check("ar_full_ready", 64'(arready_up), 64'd0);
        check("ar_full_addr", 64'(araddr_dn), 64'h100);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_async_valid", 64'(arvalid_dn), 64'd0);
        check("ar_async_ready", 64'(arready_up), 64'd1);
        check("ar_async_addr", 64'(araddr_dn), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        arready_dn = 1'b1;
        arvalid_up = 1'b1; araddr_up = 32'h40; arid_up = 4'd2;
        tick();
        arvalid_up = 1'b0;
        repeat (3) tick();
        check("ar_after_rst_count", 64'(ar_q.size()), 64'd1);
        bt = (ar_q.size() > 0) ? ar_q[0] : '1;
        check("ar_after_rst_addr", 64'(bt.d), 64'h40);

        // AW wire-through instance: combinational within one cycle
        awready_dn = 1'b0; awvalid_up = 1'b1; awaddr_up = 32'h2222;
        #1;
        check("pass_aw_valid_now", 64'(p_awvalid_dn), 64'd1);
        check("pass_aw_addr_now", 64'(p_awaddr_dn), 64'h2222);
        check("pass_aw_ready_low", 64'(p_awready_up), 64'd0);
        awready_dn = 1'b1;
        #1;
        check("pass_aw_ready_high", 64'(p_awready_up), 64'd1);
        awvalid_up = 1'b0;
        #1;
        check("pass_aw_valid_drop", 64'(p_awvalid_dn), 64'd0);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
